// File: rtl/sdram_port_arbiter_if.sv
// Signal bundle around the SDRAM port arbiter: download writer, CPU port, ROM port
// and the SDRAM controller user port, all in the clk57 domain.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 20
);
    logic              dl_wr;
    logic [24:0]       dl_addr;
    logic [7:0]        dl_data;
    logic              dl_busy;
    logic              dl_ovf;

    logic              cpu_rd;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_din;
    logic [7:0]        cpu_dout;
    logic              cpu_ack;

    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_dout;
    logic              rom_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic              mem_ack;

    // The arbiter itself.
    modport slave (
        input  dl_wr, dl_addr, dl_data,
        input  cpu_rd, cpu_wr, cpu_addr, cpu_din,
        input  rom_rd, rom_addr,
        input  mem_dout, mem_ack,
        output dl_busy, dl_ovf,
        output cpu_dout, cpu_ack,
        output rom_dout, rom_ack,
        output mem_req, mem_we, mem_addr, mem_din
    );

    // Everything around it: the requesters and the SDRAM controller.
    modport master (
        output dl_wr, dl_addr, dl_data,
        output cpu_rd, cpu_wr, cpu_addr, cpu_din,
        output rom_rd, rom_addr,
        output mem_dout, mem_ack,
        input  dl_busy, dl_ovf,
        input  cpu_dout, cpu_ack,
        input  rom_dout, rom_ack,
        input  mem_req, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM user port between a one-deep download write buffer (highest priority)
// and the CPU / ROM ports (round-robin), one req/ack transaction at a time.
module sdram_port_arbiter #(
    parameter int              ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] DL_BASE  = 20'h00000,
    parameter logic [ADDR_W-1:0] DL_LIMIT = 20'h10000
) (
    input logic                 clk,
    input logic                 reset,
    sdram_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        G_DL,
        G_CPU,
        G_ROM
    } grant_t;

    state_t            state;
    grant_t            grant;
    logic              last_rom;
    logic              excl_cpu;
    logic              excl_rom;
    logic [ADDR_W-1:0] dl_buf_addr;
    logic [7:0]        dl_buf_data;

    logic [24:0]       dl_sum;
    logic              dl_accept;
    logic              dl_emptying;
    logic              dl_free;
    logic              cpu_elig;
    logic              rom_elig;

    // Upper download-address bits must be clear and the offset address must stay below the limit.
    function automatic logic dl_in_range(input logic [24:0] addr, input logic [24:0] sum);
        return (addr[24:ADDR_W] == '0) && (sum < 25'(DL_LIMIT));
    endfunction

    assign dl_sum      = bus.dl_addr + 25'(DL_BASE);
    assign dl_accept   = bus.dl_wr && dl_in_range(bus.dl_addr, dl_sum);
    assign dl_emptying = (state == S_BUSY) && (grant == G_DL) && bus.mem_ack;
    assign dl_free     = !bus.dl_busy || dl_emptying;

    // A port acked in the previous cycle sits out one IDLE so it can drop its level.
    assign cpu_elig = (bus.cpu_rd || bus.cpu_wr) && !excl_cpu;
    assign rom_elig = bus.rom_rd && !excl_rom;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.dl_busy <= 1'b0;
            bus.dl_ovf  <= 1'b0;
        end else begin
            if (dl_emptying) begin
                bus.dl_busy <= 1'b0;
            end
            if (dl_accept) begin
                if (dl_free) begin
                    bus.dl_busy <= 1'b1;
                end else begin
                    bus.dl_ovf <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dl_accept && dl_free) begin
            dl_buf_addr <= dl_sum[ADDR_W-1:0];
            dl_buf_data <= bus.dl_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            grant        <= G_CPU;
            last_rom     <= 1'b1;
            excl_cpu     <= 1'b0;
            excl_rom     <= 1'b0;
            bus.mem_req  <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
            bus.cpu_ack  <= 1'b0;
            bus.rom_ack  <= 1'b0;
            bus.cpu_dout <= '0;
            bus.rom_dout <= '0;
        end else begin
            bus.cpu_ack <= 1'b0;
            bus.rom_ack <= 1'b0;
            excl_cpu    <= 1'b0;
            excl_rom    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.dl_busy) begin
                        grant        <= G_DL;
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b1;
                        bus.mem_addr <= dl_buf_addr;
                        bus.mem_din  <= dl_buf_data;
                        state        <= S_BUSY;
                    end else if (cpu_elig && (!rom_elig || last_rom)) begin
                        grant        <= G_CPU;
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= bus.cpu_wr;
                        bus.mem_addr <= bus.cpu_addr;
                        bus.mem_din  <= bus.cpu_din;
                        state        <= S_BUSY;
                    end else if (rom_elig) begin
                        grant        <= G_ROM;
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= bus.rom_addr;
                        bus.mem_din  <= '0;
                        state        <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        state       <= S_DONE;
                        if (grant == G_CPU) begin
                            bus.cpu_ack <= 1'b1;
                            if (!bus.mem_we) begin
                                bus.cpu_dout <= bus.mem_dout;
                            end
                        end else if (grant == G_ROM) begin
                            bus.rom_ack <= 1'b1;
                            if (!bus.mem_we) begin
                                bus.rom_dout <= bus.mem_dout;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    if (grant == G_CPU) begin
                        last_rom <= 1'b0;
                        excl_cpu <= 1'b1;
                    end else if (grant == G_ROM) begin
                        last_rom <= 1'b1;
                        excl_rom <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: a transaction-level model predicts the order of
// SDRAM accesses and the data each port gets back; a monitor compares as the DUT presents them.
module tb_sdram_port_arbiter;

    localparam int          ADDR_W   = 20;
    localparam logic [19:0] DL_BASE  = 20'h08000;
    localparam logic [19:0] DL_LIMIT = 20'h10000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    sdram_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DL_BASE (DL_BASE),
        .DL_LIMIT(DL_LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected SDRAM accesses {we, addr, din} and per-port read data, in service order.
    logic [28:0] acc_q[$];
    logic [7:0]  cpu_q[$];
    logic [7:0]  rom_q[$];

    logic [7:0] rmem[int];
    logic [7:0] cmem[int];
    bit         last_rom_m;
    logic [7:0] cpu_dout_m;
    bit         ovf_m;

    int  cpu_left, rom_left;
    bit  hold;
    int  lat_min, lat_max;
    int  t_req, t_cpu_ack;
    logic [7:0] cpu_seen, rom_seen;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    endtask

    function automatic logic [7:0] mem_init(input int a);
        return 8'(a * 37 + 11);
    endfunction

    function automatic logic [7:0] rd_ref(input int a);
        return rmem.exists(a) ? rmem[a] : mem_init(a);
    endfunction

    task automatic model_reset();
        last_rom_m = 1'b1;
        cpu_dout_m = 8'h00;
        ovf_m      = 1'b0;
    endtask

    task automatic exp_dl(input logic [24:0] a, input logic [7:0] d);
        int sum;
        sum = int'(a) + int'(DL_BASE);
        if (int'(a) < (1 << 20) && sum < int'(DL_LIMIT)) begin
            acc_q.push_back({1'b1, 20'(sum), d});
            rmem[sum] = d;
        end
    endtask

    task automatic exp_cpu(input int op, input logic [19:0] a, input logic [7:0] d);
        if (op == 2) begin
            acc_q.push_back({1'b1, a, d});
            rmem[int'(a)] = d;
        end else begin
            cpu_dout_m = rd_ref(int'(a));
            acc_q.push_back({1'b0, a, d});
        end
        cpu_q.push_back(cpu_dout_m);
        last_rom_m = 1'b0;
    endtask

    task automatic exp_rom(input logic [19:0] a);
        logic [7:0] v;
        v = rd_ref(int'(a));
        acc_q.push_back({1'b0, a, 8'h00});
        rom_q.push_back(v);
        last_rom_m = 1'b1;
    endtask

    // Service order: buffered download first, then CPU/ROM by round-robin.
    task automatic plan(input bit dl, input logic [24:0] dl_a, input logic [7:0] dl_d,
                        input int cpu_op, input logic [19:0] cpu_a, input logic [7:0] cpu_d,
                        input bit rom, input logic [19:0] rom_a);
        if (dl) exp_dl(dl_a, dl_d);
        if (cpu_op != 0 && rom) begin
            if (last_rom_m) begin
                exp_cpu(cpu_op, cpu_a, cpu_d);
                exp_rom(rom_a);
            end else begin
                exp_rom(rom_a);
                exp_cpu(cpu_op, cpu_a, cpu_d);
            end
        end else if (cpu_op != 0) begin
            exp_cpu(cpu_op, cpu_a, cpu_d);
        end else if (rom) begin
            exp_rom(rom_a);
        end
    endtask

    task automatic issue(input bit dl, input logic [24:0] dl_a, input logic [7:0] dl_d,
                         input int cpu_op, input logic [19:0] cpu_a, input logic [7:0] cpu_d,
                         input bit rom, input logic [19:0] rom_a);
        plan(dl, dl_a, dl_d, cpu_op, cpu_a, cpu_d, rom, rom_a);
        @(negedge clk);
        bus.dl_wr   = dl;
        bus.dl_addr = dl_a;
        bus.dl_data = dl_d;
        @(negedge clk);
        bus.dl_wr    = 1'b0;
        bus.cpu_rd   = (cpu_op == 1);
        bus.cpu_wr   = (cpu_op == 2);
        bus.cpu_addr = cpu_a;
        bus.cpu_din  = cpu_d;
        bus.rom_rd   = rom;
        bus.rom_addr = rom_a;
        cpu_left     = (cpu_op != 0) ? 1 : 0;
        rom_left     = rom ? 1 : 0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((acc_q.size() != 0 || cpu_q.size() != 0 || rom_q.size() != 0 || cpu_left != 0 ||
                rom_left != 0 || bus.dl_busy || bus.mem_req) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_complete"}, 32'(n < 300), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!bus.mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_req_seen"}, 32'(bus.mem_req), 1);
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_mem_req"}, 32'(bus.mem_req), 0);
        chk({p, "_mem_we"}, 32'(bus.mem_we), 0);
        chk({p, "_mem_addr"}, 32'(bus.mem_addr), 0);
        chk({p, "_mem_din"}, 32'(bus.mem_din), 0);
        chk({p, "_cpu_ack"}, 32'(bus.cpu_ack), 0);
        chk({p, "_rom_ack"}, 32'(bus.rom_ack), 0);
        chk({p, "_cpu_dout"}, 32'(bus.cpu_dout), 0);
        chk({p, "_rom_dout"}, 32'(bus.rom_dout), 0);
        chk({p, "_dl_busy"}, 32'(bus.dl_busy), 0);
        chk({p, "_dl_ovf"}, 32'(bus.dl_ovf), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
        bus.rom_rd = 1'b0;
        bus.dl_wr  = 1'b0;
        cpu_left   = 0;
        rom_left   = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // SDRAM controller: a memory with a per-access latency drawn from [lat_min, lat_max].
    initial begin : controller
        bit counting;
        int wait_cnt;
        int a;
        counting = 1'b0;
        wait_cnt = 0;
        bus.mem_ack  = 1'b0;
        bus.mem_dout = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) counting = 1'b0;
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
            end else if (bus.mem_req && !hold && !reset) begin
                if (!counting) begin
                    counting = 1'b1;
                    wait_cnt = int'($urandom_range(lat_max, lat_min));
                end
                if (wait_cnt == 0) begin
                    a = int'(bus.mem_addr);
                    if (bus.mem_we) cmem[a] = bus.mem_din;
                    else bus.mem_dout = cmem.exists(a) ? cmem[a] : mem_init(a);
                    bus.mem_ack = 1'b1;
                    counting    = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Requesters drop their level once they have seen the expected number of acks.
    initial begin : requesters
        forever begin
            @(negedge clk);
            if (bus.cpu_ack && cpu_left > 0) begin
                cpu_left--;
                if (cpu_left == 0) begin
                    bus.cpu_rd = 1'b0;
                    bus.cpu_wr = 1'b0;
                end
            end
            if (bus.rom_ack && rom_left > 0) begin
                rom_left--;
                if (rom_left == 0) bus.rom_rd = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic        prev_req;
        logic [28:0] prev_acc, cur, e;
        logic [7:0]  d;
        prev_req = 1'b0;
        prev_acc = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req = 1'b0;
                cpu_seen = 8'h00;
                rom_seen = 8'h00;
            end else begin
                cur = {bus.mem_we, bus.mem_addr, bus.mem_din};
                if (bus.mem_req && !prev_req) begin
                    t_req = cyc;
                    chk("req_expected", 32'(acc_q.size() != 0), 1);
                    if (acc_q.size() != 0) begin
                        e = acc_q.pop_front();
                        chk("req_we_addr", 32'(cur[28:8]), 32'(e[28:8]));
                        if (e[28]) chk("req_din", 32'(cur[7:0]), 32'(e[7:0]));
                    end
                end else if (bus.mem_req && prev_req) begin
                    chk("req_stable", 32'(cur), 32'(prev_acc));
                end
                prev_req = bus.mem_req;
                prev_acc = cur;
                if (bus.cpu_ack) begin
                    t_cpu_ack = cyc;
                    chk("cpu_ack_expected", 32'(cpu_q.size() != 0), 1);
                    chk("rom_dout_hold", 32'(bus.rom_dout), 32'(rom_seen));
                    if (cpu_q.size() != 0) begin
                        d = cpu_q.pop_front();
                        chk("cpu_dout", 32'(bus.cpu_dout), 32'(d));
                        cpu_seen = d;
                    end
                end
                if (bus.rom_ack) begin
                    chk("rom_ack_expected", 32'(rom_q.size() != 0), 1);
                    chk("cpu_dout_hold", 32'(bus.cpu_dout), 32'(cpu_seen));
                    if (rom_q.size() != 0) begin
                        d = rom_q.pop_front();
                        chk("rom_dout", 32'(bus.rom_dout), 32'(d));
                        rom_seen = d;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset        = 1'b1;
        bus.dl_wr    = 1'b0;
        bus.dl_addr  = '0;
        bus.dl_data  = '0;
        bus.cpu_rd   = 1'b0;
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_din  = '0;
        bus.rom_rd   = 1'b0;
        bus.rom_addr = '0;
        hold         = 1'b0;
        lat_min      = 0;
        lat_max      = 0;
        cpu_left     = 0;
        rom_left     = 0;
        t_req        = 0;
        t_cpu_ack    = 0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst");

        // Single CPU write, controller answers two cycles after mem_req.
        lat_min = 2;
        lat_max = 2;
        issue(1'b0, '0, '0, 2, 20'h01234, 8'hA5, 1'b0, '0);
        wait_idle("cpu_wr");
        chk("cpu_wr_req_to_ack", 32'(t_cpu_ack - t_req), 3);

        // ROM read data return.
        cmem[20'h0C000] = 8'h7E;
        rmem[20'h0C000] = 8'h7E;
        lat_min = 0;
        lat_max = 2;
        issue(1'b0, '0, '0, 0, '0, '0, 1'b1, 20'h0C000);
        wait_idle("rom_rd");
        chk("rom_dout_7e", 32'(bus.rom_dout), 32'h7E);
        chk("cpu_dout_untouched", 32'(bus.cpu_dout), 0);

        // Round-robin with both levels held and instant controller.
        do_reset();
        lat_min = 0;
        lat_max = 0;
        begin
            int cl, rl;
            cl = 2;
            rl = 2;
            while (cl != 0 || rl != 0) begin
                if (cl != 0 && (rl == 0 || last_rom_m)) begin
                    exp_cpu(1, 20'h00100, 8'h00);
                    cl--;
                end else begin
                    exp_rom(20'h00200);
                    rl--;
                end
            end
        end
        @(negedge clk);
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 20'h00100;
        bus.cpu_din  = 8'h00;
        bus.rom_rd   = 1'b1;
        bus.rom_addr = 20'h00200;
        cpu_left     = 2;
        rom_left     = 2;
        wait_idle("round_robin");

        // Download takes priority over a waiting CPU request.
        hold = 1'b1;
        exp_rom(20'h00300);
        @(negedge clk);
        bus.rom_rd   = 1'b1;
        bus.rom_addr = 20'h00300;
        rom_left     = 1;
        wait_req("dlprio_rom");
        exp_dl(25'h10, 8'h3C);
        exp_cpu(2, 20'h00400, 8'h99);
        bus.dl_wr   = 1'b1;
        bus.dl_addr = 25'h10;
        bus.dl_data = 8'h3C;
        @(negedge clk);
        bus.dl_wr    = 1'b0;
        bus.cpu_wr   = 1'b1;
        bus.cpu_addr = 20'h00400;
        bus.cpu_din  = 8'h99;
        cpu_left     = 1;
        chk("dlprio_busy_set", 32'(bus.dl_busy), 1);
        lat_max = 2;
        hold    = 1'b0;
        wait_idle("dl_priority");
        chk("dlprio_busy_clear", 32'(bus.dl_busy), 0);

        // Overflow: second strobe while the first is still in flight.
        hold = 1'b1;
        exp_dl(25'h20, 8'h11);
        ovf_m = 1'b1;
        @(negedge clk);
        bus.dl_wr   = 1'b1;
        bus.dl_addr = 25'h20;
        bus.dl_data = 8'h11;
        @(negedge clk);
        bus.dl_wr = 1'b0;
        @(negedge clk);
        bus.dl_wr   = 1'b1;
        bus.dl_addr = 25'h21;
        bus.dl_data = 8'h22;
        @(negedge clk);
        bus.dl_wr = 1'b0;
        chk("ovf_set", 32'(bus.dl_ovf), 32'(ovf_m));
        hold = 1'b0;
        wait_idle("overflow");
        chk("ovf_sticky", 32'(bus.dl_ovf), 32'(ovf_m));

        // Writes at the limit or with high address bits set are dropped, not overflows.
        issue(1'b1, 25'h08000, 8'h55, 0, '0, '0, 1'b0, '0);
        chk("limit_no_busy", 32'(bus.dl_busy), 0);
        wait_idle("limit");
        issue(1'b1, 25'h1000010, 8'h66, 0, '0, '0, 1'b0, '0);
        chk("hibits_no_busy", 32'(bus.dl_busy), 0);
        wait_idle("hibits");
        chk("limit_ovf_unchanged", 32'(bus.dl_ovf), 32'(ovf_m));

        // Reset in the middle of an access, then a stray mem_ack in IDLE.
        hold = 1'b1;
        acc_q.push_back({1'b0, 20'h00500, 8'h00});
        @(negedge clk);
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 20'h00500;
        wait_req("rstbusy");
        do_reset();
        bus.mem_dout = 8'hEE;
        bus.mem_ack  = 1'b1;
        @(negedge clk);
        chk_reset_vals("rstbusy");
        repeat (2) @(negedge clk);
        chk("rstbusy_no_req", 32'(bus.mem_req), 0);
        hold    = 1'b0;
        lat_min = 0;
        lat_max = 3;
        issue(1'b0, '0, '0, 1, 20'h00600, 8'h00, 1'b0, '0);
        wait_idle("after_reset");

        // Randomised mixes of download, CPU and ROM traffic over a shared address window.
        for (int it = 0; it < 40; it++) begin
            bit          dl, rom;
            int          cpu_op;
            logic [24:0] dl_a;
            logic [19:0] ca, ra;
            dl = 1'($urandom_range(1, 0));
            case ($urandom_range(5, 0))
                0:       dl_a = 25'h08000 + 25'($urandom_range(3, 0));
                1:       dl_a = 25'h1000000 | 25'($urandom_range(15, 0));
                default: dl_a = 25'($urandom_range(15, 0));
            endcase
            cpu_op = int'($urandom_range(2, 0));
            ca     = 20'h08000 + 20'($urandom_range(15, 0));
            rom    = 1'($urandom_range(1, 0));
            ra     = 20'h08000 + 20'($urandom_range(15, 0));
            issue(dl, dl_a, 8'($urandom()), cpu_op, ca, 8'($urandom()), rom, ra);
            wait_idle("random");
        end
        chk("final_ovf", 32'(bus.dl_ovf), 32'(ovf_m));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
